prach_ditfft3_bf2: RTL and testbench

PRACH_DITFFT3_BF2 -- requirements
Module: prach_ditfft3_bf2

---
 rtl/prach_pkg.sv | 16 +
 rtl/prach_ditfft3_bf2_delay.sv | 21 ++
 rtl/prach_ditfft3_bf2.sv | 82 ++++++++
 tb/tb_prach_ditfft3_bf2.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/prach_pkg.sv
// prach_pkg: shared sample type, twiddle constant and output rounding for the PRACH DFT stages.
// Output saturation is selected by PRACH_DITFFT3_BF2_SAT_EN (otherwise results wrap).
package prach_pkg;
    typedef logic signed [17:0] sample_t;
    typedef logic [1:0] idx_t;
    localparam sample_t SQRT3_2 = 18'sd113512;
    function automatic sample_t rnd_narrow(input logic signed [20:0] v);
        logic signed [20:0] t;
        t = (v + 21'sd2) >>> 2;
`ifdef PRACH_DITFFT3_BF2_SAT_EN
        return (t > 21'sd131071) ? 18'sd131071 : (t < -21'sd131072) ? -18'sd131072 : 18'(t);
`else
        return 18'(t);
`endif
    endfunction
endpackage

// File: rtl/prach_ditfft3_bf2_delay.sv
// prach_ditfft3_bf2_delay: resettable fixed-length shift register for control alignment.
module prach_ditfft3_bf2_delay #(
    parameter int WIDTH = 2,
    parameter int DELAY = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] sr [DELAY];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '{default: '0};
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DELAY; i++) sr[i] <= sr[i-1];
        end
    end
    assign dout = sr[DELAY-1];
endmodule

// File: rtl/prach_ditfft3_bf2.sv
// prach_ditfft3_bf2: second radix-3 butterfly, turns the bf1 a/s/d triple into X0/X1/X2 (gain 1/2, 4-cycle latency).
// Define PRACH_DITFFT3_BF2_SAT_EN to saturate outputs instead of wrapping.
module prach_ditfft3_bf2
    import prach_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic signed [17:0]  din_dr,
    input  logic signed [17:0]  din_di,
    input  logic                din_dv,
    input  logic                sync_in,
    output logic signed [17:0]  dout_dr,
    output logic signed [17:0]  dout_di,
    output logic                dout_dv,
    output logic                sync_out
);
    idx_t cnt, idx;
    idx_t idx_d [3];
    sample_t a_re, a_im, s_re, s_im, d_re, d_im;
    sample_t ap_re, ap_im, sp_re, sp_im, m_re, m_im, mq_re, mq_im;
    logic signed [35:0] p_re, p_im;
    logic signed [20:0] h_re, h_im, v_re, v_im;

    assign idx = sync_in ? 2'd0 : cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 2'd0;
            idx_d <= '{default: 2'd0};
        end else begin
            if (din_dv) cnt <= sync_in ? 2'd1 : (cnt == 2'd2) ? 2'd0 : cnt + 2'd1;
            idx_d[0] <= idx;
            idx_d[1] <= idx_d[0];
            idx_d[2] <= idx_d[1];
        end
    end

    // X0 needs only a and s; X1/X2 use a snapshot taken once m is known so the next triple can refill a/s/d
    always_ff @(posedge clk) begin
        if (din_dv && idx == 2'd0) begin a_re <= din_dr; a_im <= din_di; end
        if (din_dv && idx == 2'd1) begin s_re <= din_dr; s_im <= din_di; end
        if (din_dv && idx == 2'd2) begin d_re <= din_dr; d_im <= din_di; end
        if (idx_d[0] == 2'd2) begin
            mq_re <= m_re;
            mq_im <= m_im;
            ap_re <= a_re;
            ap_im <= a_im;
            sp_re <= s_re;
            sp_im <= s_im;
        end
    end

    always_comb begin
        p_re = d_re * SQRT3_2 + 36'sd65536;
        p_im = d_im * SQRT3_2 + 36'sd65536;
        m_re = 18'(p_re >>> 17);
        m_im = 18'(p_im >>> 17);
        h_re = (21'(ap_re) <<< 1) - 21'(sp_re);
        h_im = (21'(ap_im) <<< 1) - 21'(sp_im);
        v_re = (idx_d[2] == 2'd0) ? (21'(a_re) + 21'(s_re)) <<< 1 :
               (idx_d[2] == 2'd1) ? h_re - (21'(mq_im) <<< 1) : h_re + (21'(mq_im) <<< 1);
        v_im = (idx_d[2] == 2'd0) ? (21'(a_im) + 21'(s_im)) <<< 1 :
               (idx_d[2] == 2'd1) ? h_im + (21'(mq_re) <<< 1) : h_im - (21'(mq_re) <<< 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_dr <= '0;
            dout_di <= '0;
        end else begin
            dout_dr <= rnd_narrow(v_re);
            dout_di <= rnd_narrow(v_im);
        end
    end

    prach_ditfft3_bf2_delay #(.WIDTH(2), .DELAY(4)) u_dly (
        .clk  (clk),
        .rst_n(rst_n),
        .din  ({din_dv, sync_in}),
        .dout ({dout_dv, sync_out})
    );
endmodule

// File: tb/tb_prach_ditfft3_bf2.sv
// tb_prach_ditfft3_bf2: directed/random scoreboard bench for prach_ditfft3_bf2.
// Expectations follow PRACH_DITFFT3_BF2_SAT_EN when it is defined.
module tb_prach_ditfft3_bf2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic signed [17:0] din_dr = '0, din_di = '0;
    logic din_dv = 1'b0, sync_in = 1'b0;
    logic signed [17:0] dout_dr, dout_di;
    logic dout_dv, sync_out;

    typedef struct {bit chk; int re; int im; bit sy;} exp_t;
    exp_t q[$];
    int n_tests = 0, n_fail = 0, sync_cnt = 0;
    bit hv[4], hs[4];

    prach_ditfft3_bf2 dut (
        .clk(clk), .rst_n(rst_n),
        .din_dr(din_dr), .din_di(din_di), .din_dv(din_dv), .sync_in(sync_in),
        .dout_dr(dout_dr), .dout_di(dout_di), .dout_dv(dout_dv), .sync_out(sync_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint fdiv(input longint n, input longint d);
        return (n >= 0) ? n / d : -((-n + d - 1) / d);
    endfunction

    function automatic int narrow(input longint v);
        longint t;
        t = fdiv(v + 2, 4);
`ifdef PRACH_DITFFT3_BF2_SAT_EN
        if (t > 131071) t = 131071;
        if (t < -131072) t = -131072;
`else
        t = t - 262144 * fdiv(t + 131072, 262144);
`endif
        return int'(t);
    endfunction

    function automatic logic signed [17:0] rnd18();
        return 18'($urandom);
    endfunction

    task automatic push(input bit chk, input int re, input int im, input bit sy);
        exp_t e;
        e.chk = chk; e.re = re; e.im = im; e.sy = sy;
        q.push_back(e);
    endtask

    // golden radix-3 second stage: X = (2a + {2s, -s +/- 2jm}) / 4
    task automatic push_model(input longint ar, ai, sr, si, dr, di);
        longint mr, mi;
        mr = fdiv(dr * 113512 + 65536, 131072);
        mi = fdiv(di * 113512 + 65536, 131072);
        push(1, narrow(2*ar + 2*sr), narrow(2*ai + 2*si), 1);
        push(1, narrow(2*ar - sr - 2*mi), narrow(2*ai - si + 2*mr), 0);
        push(1, narrow(2*ar - sr + 2*mi), narrow(2*ai - si - 2*mr), 0);
    endtask

    task automatic send(input logic signed [17:0] re, im, input bit dv, sy);
        din_dr = re; din_di = im; din_dv = dv; sync_in = sy;
        @(posedge clk);
        #1;
        din_dv = 1'b0; sync_in = 1'b0;
    endtask

    task automatic triple_raw(input logic signed [17:0] ar, ai, sr, si, dr, di);
        send(ar, ai, 1, 1);
        send(sr, si, 1, 0);
        send(dr, di, 1, 0);
    endtask

    task automatic triple_rand();
        logic signed [17:0] v [6];
        foreach (v[i]) v[i] = rnd18();
        push_model(v[0], v[1], v[2], v[3], v[4], v[5]);
        triple_raw(v[0], v[1], v[2], v[3], v[4], v[5]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() > 0; i++) begin @(posedge clk); #1; end
        check("drain_empty", q.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hv = '{default: 1'b0};
            hs = '{default: 1'b0};
        end else begin
            check("dout_dv", dout_dv, hv[3]);
            check("sync_out", sync_out, hs[3]);
            if (dout_dv === 1'b1) begin
                if (sync_out === 1'b1) sync_cnt++;
                check("sb_nonempty", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("sb_sync", sync_out, e.sy);
                    if (e.chk) begin
                        check("dout_dr", dout_dr, e.re);
                        check("dout_di", dout_di, e.im);
                    end
                end
            end
            for (int i = 3; i > 0; i--) begin hv[i] = hv[i-1]; hs[i] = hs[i-1]; end
            hv[0] = din_dv;
            hs[0] = sync_in;
        end
    end

    initial begin
        int s0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout_dv", dout_dv, 0);
        check("rst_sync_out", sync_out, 0);
        check("rst_dout_dr", dout_dr, 0);
        check("rst_dout_di", dout_di, 0);
        rst_n = 1'b1;
        idle(2);
        push(1, 1500, 0, 1); push(1, 0, 0, 0); push(1, 0, 0, 0);
        triple_raw(18'sd1000, 18'sd0, 18'sd2000, 18'sd0, 18'sd0, 18'sd0);
        push(1, 0, 0, 1); push(1, -433, 0, 0); push(1, 433, 0, 0);
        triple_raw(18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd1000);
        idle(3);
        push(1, 0, 0, 1);
`ifdef PRACH_DITFFT3_BF2_SAT_EN
        push(1, 131071, 0, 0);
`else
        push(1, -107084, 0, 0);
`endif
        push(1, 41548, 0, 0);
        triple_raw(18'sd131071, 18'sd0, -18'sd131072, 18'sd0, 18'sd0, -18'sd131072);
        drain();
        s0 = sync_cnt;
        repeat (3) triple_rand();
        idle(5);
        triple_rand();
        drain();
        check("sync_pulses", sync_cnt - s0, 4);
        triple_rand();
        send(rnd18(), rnd18(), 1, 1);
        send(rnd18(), rnd18(), 1, 0);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        check("async_rst_dv", dout_dv, 0);
        check("async_rst_sync", sync_out, 0);
        check("async_rst_dr", dout_dr, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(6);
        triple_rand();
        drain();
        push(0, 0, 0, 1);
        send(rnd18(), rnd18(), 1, 1);
        triple_rand();
        triple_rand();
        drain();
        idle(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
